// File: rtl/frame_scheduler.sv
// frame_scheduler: raster timing generator with a one-deep processing-mode slot.
// After start it sweeps (out_vcnt, out_hcnt) over V_FRAME x H_FRAME, flags the
// active region on out_vde, and pulses frame_start at (0,0). A stop request
// lets the current frame finish, then DRAIN waits LATENCY cycles for the
// downstream pipeline before returning to IDLE. frame_done marks the last
// pixel of each frame leaving that pipeline, LATENCY cycles after it is issued.
// Ports:
//   clk, rst         - clock, asynchronous active-low reset
//   start, stop      - single-cycle run / halt-after-frame requests
//   cfg_valid/_mode  - mode update offered into the pending slot
//   cfg_ready        - pending slot empty
//   out_vcnt/_hcnt   - line / pixel counters
//   out_vde          - active-region flag aligned with the counters
//   active_mode      - mode applied to the current frame
//   frame_start      - pulse at (0,0) while running
//   frame_done       - pulse when a frame's last pixel leaves the pipeline
//   busy             - high in RUN or DRAIN
module frame_scheduler #(
   parameter int H_ACTIVE   = -1,
   parameter int V_ACTIVE   = -1,
   parameter int H_FRAME    = -1,
   parameter int V_FRAME    = -1,
   parameter int MODE_WIDTH = 2,
   parameter int LATENCY    = 4,
   localparam int unsigned HW = (H_FRAME > 1) ? $clog2(H_FRAME) : 1,
   localparam int unsigned VW = (V_FRAME > 1) ? $clog2(V_FRAME) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  cfg_valid,
   input  logic [MODE_WIDTH-1:0] cfg_mode,
   output logic                  cfg_ready,
   output logic [VW-1:0]         out_vcnt,
   output logic [HW-1:0]         out_hcnt,
   output logic                  out_vde,
   output logic [MODE_WIDTH-1:0] active_mode,
   output logic                  frame_start,
   output logic                  frame_done,
   output logic                  busy
);

   localparam int unsigned DW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int unsigned H_ACT_U = (H_ACTIVE > 0) ? 32'(H_ACTIVE) : 32'd0;
   localparam int unsigned V_ACT_U = (V_ACTIVE > 0) ? 32'(V_ACTIVE) : 32'd0;
   localparam logic [HW-1:0] H_LAST = HW'(H_FRAME - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_FRAME - 1);
   localparam logic [DW-1:0] D_LAST = DW'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                  state, state_nxt;
   logic [HW-1:0]           hcnt_nxt;
   logic [VW-1:0]           vcnt_nxt;
   logic                    stop_pending, stop_pending_nxt;
   logic [DW-1:0]           drain_cnt, drain_cnt_nxt;
   logic [LATENCY-1:0]      done_pipe, done_pipe_nxt;
   logic                    last_pix;
   logic                    fs_nxt, vde_nxt, busy_nxt;
   logic                    pend_full, pend_full_nxt;
   logic [MODE_WIDTH-1:0]   pend_mode, pend_mode_nxt;
   logic [MODE_WIDTH-1:0]   active_mode_nxt;
   logic                    applied, applied_nxt;
   logic                    cfg_ready_nxt;

   assign frame_done = done_pipe[LATENCY-1];

   // Next-state, counter, pipeline and mode-slot logic
   always_comb begin
      state_nxt        = state;
      hcnt_nxt         = out_hcnt;
      vcnt_nxt         = out_vcnt;
      stop_pending_nxt = stop_pending;
      drain_cnt_nxt    = drain_cnt;
      active_mode_nxt  = active_mode;
      pend_mode_nxt    = pend_mode;
      pend_full_nxt    = pend_full;
      applied_nxt      = 1'b0;
      done_pipe_nxt    = '0;

      last_pix = (state == S_RUN) && (out_hcnt == H_LAST) && (out_vcnt == V_LAST);

      case (state)
         S_IDLE: begin
            hcnt_nxt         = '0;
            vcnt_nxt         = '0;
            stop_pending_nxt = 1'b0;
            if (start) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (stop) begin
               stop_pending_nxt = 1'b1;
            end
            if (out_hcnt == H_LAST) begin
               hcnt_nxt = '0;
               vcnt_nxt = (out_vcnt == V_LAST) ? '0 : out_vcnt + VW'(1);
            end else begin
               hcnt_nxt = out_hcnt + HW'(1);
            end
            if (last_pix && (stop_pending || stop)) begin
               state_nxt        = S_DRAIN;
               drain_cnt_nxt    = '0;
               stop_pending_nxt = 1'b0;
            end
         end
         S_DRAIN: begin
            hcnt_nxt = '0;
            vcnt_nxt = '0;
            if (drain_cnt == D_LAST) begin
               state_nxt = S_IDLE;
            end else begin
               drain_cnt_nxt = drain_cnt + DW'(1);
            end
         end
         default: begin
            state_nxt = S_IDLE;
            hcnt_nxt  = '0;
            vcnt_nxt  = '0;
         end
      endcase

      fs_nxt   = (state_nxt == S_RUN) && (hcnt_nxt == '0) && (vcnt_nxt == '0);
      vde_nxt  = (state_nxt == S_RUN) && (32'(vcnt_nxt) < V_ACT_U) &&
                 (32'(hcnt_nxt) < H_ACT_U);
      busy_nxt = (state_nxt != S_IDLE);

      // Last-pixel marker delayed by the downstream pipeline depth
      done_pipe_nxt[0] = last_pix;
      for (int i = 1; i < LATENCY; i++) begin
         done_pipe_nxt[i] = done_pipe[i-1];
      end

      // Mode slot: outside RUN apply at once; in RUN copy as frame_start is
      // raised and free the slot one cycle later, so a mode landing in the
      // frame_start cycle waits for the following frame.
      if (state != S_RUN) begin
         if (pend_full) begin
            active_mode_nxt = pend_mode;
            pend_full_nxt   = 1'b0;
         end
      end else if (applied) begin
         pend_full_nxt = 1'b0;
      end else if (pend_full && fs_nxt) begin
         active_mode_nxt = pend_mode;
         applied_nxt     = 1'b1;
      end

      if (cfg_valid && cfg_ready) begin
         pend_mode_nxt = cfg_mode;
         pend_full_nxt = 1'b1;
      end

      cfg_ready_nxt = ~pend_full_nxt;
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         out_hcnt     <= '0;
         out_vcnt     <= '0;
         out_vde      <= 1'b0;
         frame_start  <= 1'b0;
         busy         <= 1'b0;
         stop_pending <= 1'b0;
         drain_cnt    <= '0;
         done_pipe    <= '0;
         active_mode  <= '0;
         pend_mode    <= '0;
         pend_full    <= 1'b0;
         applied      <= 1'b0;
         cfg_ready    <= 1'b1;
      end else begin
         state        <= state_nxt;
         out_hcnt     <= hcnt_nxt;
         out_vcnt     <= vcnt_nxt;
         out_vde      <= vde_nxt;
         frame_start  <= fs_nxt;
         busy         <= busy_nxt;
         stop_pending <= stop_pending_nxt;
         drain_cnt    <= drain_cnt_nxt;
         done_pipe    <= done_pipe_nxt;
         active_mode  <= active_mode_nxt;
         pend_mode    <= pend_mode_nxt;
         pend_full    <= pend_full_nxt;
         applied      <= applied_nxt;
         cfg_ready    <= cfg_ready_nxt;
      end
   end

endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler: directed per-cycle vector tables for frame_scheduler
// (H_ACTIVE=6, V_ACTIVE=3, H_FRAME=8, V_FRAME=4, LATENCY=4) plus a
// hand-written asynchronous-reset sequence.
module tb_frame_scheduler;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stop;
   logic       cfg_valid;
   logic [1:0] cfg_mode;
   logic       cfg_ready;
   logic [1:0] out_vcnt;
   logic [2:0] out_hcnt;
   logic       out_vde;
   logic [1:0] active_mode;
   logic       frame_start;
   logic       frame_done;
   logic       busy;

   frame_scheduler #(
      .H_ACTIVE  (6),
      .V_ACTIVE  (3),
      .H_FRAME   (8),
      .V_FRAME   (4),
      .MODE_WIDTH(2),
      .LATENCY   (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .cfg_valid  (cfg_valid),
      .cfg_mode   (cfg_mode),
      .cfg_ready  (cfg_ready),
      .out_vcnt   (out_vcnt),
      .out_hcnt   (out_hcnt),
      .out_vde    (out_vde),
      .active_mode(active_mode),
      .frame_start(frame_start),
      .frame_done (frame_done),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One row: inputs driven during cycle cyc, outputs expected in that cycle
   typedef struct {
      int         cyc;
      logic       start;
      logic       stop;
      logic       cv;
      logic [1:0] cm;
      logic [1:0] vcnt;
      logic [2:0] hcnt;
      logic       vde;
      logic       fs;
      logic       fd;
      logic       busy;
      logic       rdy;
      logic [1:0] mode;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   vde_cnt, fs_cnt, fd_cnt, busy_cnt;

   function automatic vec_t mk(int c, logic st, logic sp, logic cv, logic [1:0] cm,
                               logic [1:0] vc, logic [2:0] hc, logic vde, logic fs,
                               logic fd, logic bz, logic rdy, logic [1:0] md);
      vec_t r;
      r.cyc = c;  r.start = st; r.stop = sp; r.cv = cv; r.cm = cm;
      r.vcnt = vc; r.hcnt = hc; r.vde = vde; r.fs = fs; r.fd = fd;
      r.busy = bz; r.rdy = rdy; r.mode = md;
      return r;
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_row(input string tag, input vec_t r);
      string p;
      p = $sformatf("%s c%0d", tag, r.cyc);
      check({p, " vcnt"},        int'(out_vcnt),    int'(r.vcnt));
      check({p, " hcnt"},        int'(out_hcnt),    int'(r.hcnt));
      check({p, " vde"},         int'(out_vde),     int'(r.vde));
      check({p, " frame_start"}, int'(frame_start), int'(r.fs));
      check({p, " frame_done"},  int'(frame_done),  int'(r.fd));
      check({p, " busy"},        int'(busy),        int'(r.busy));
      check({p, " cfg_ready"},   int'(cfg_ready),   int'(r.rdy));
      check({p, " active_mode"}, int'(active_mode), int'(r.mode));
   endtask

   task automatic apply_reset();
      rst = 1'b0; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_mode = 2'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Advance to just after the next rising edge and idle the inputs
   task automatic step();
      @(posedge clk);
      #1;
      start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_mode = 2'd0;
   endtask

   task automatic run_vecs(input string tag, input int n_cyc);
      apply_reset();
      vde_cnt = 0; fs_cnt = 0; fd_cnt = 0;
      for (int c = 0; c < n_cyc; c++) begin
         step();
         if (c >= 1 && c <= 32 && out_vde) vde_cnt++;
         if (frame_start) fs_cnt++;
         if (frame_done)  fd_cnt++;
         foreach (vecs[i]) begin
            if (vecs[i].cyc == c) begin
               check_row(tag, vecs[i]);
               start     = vecs[i].start;
               stop      = vecs[i].stop;
               cfg_valid = vecs[i].cv;
               cfg_mode  = vecs[i].cm;
            end
         end
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_mode = 2'd0;

      // Free-running raster with a mode update accepted mid-frame
      vecs.delete();
      //                 c  st sp cv cm  v  h vde fs fd bz rdy md
      vecs.push_back(mk( 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(mk( 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0));
      vecs.push_back(mk( 5, 0, 0, 1, 2, 0, 4, 1, 0, 0, 1, 1, 0));
      vecs.push_back(mk( 6, 0, 0, 0, 0, 0, 5, 1, 0, 0, 1, 0, 0));
      vecs.push_back(mk( 7, 0, 0, 0, 0, 0, 6, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk( 9, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0));
      vecs.push_back(mk(25, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(32, 0, 0, 0, 0, 3, 7, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(33, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 2));
      vecs.push_back(mk(34, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 2));
      vecs.push_back(mk(36, 0, 0, 0, 0, 0, 3, 1, 0, 1, 1, 1, 2));
      vecs.push_back(mk(37, 0, 0, 0, 0, 0, 4, 1, 0, 0, 1, 1, 2));
      vecs.push_back(mk(68, 0, 0, 0, 0, 0, 3, 1, 0, 1, 1, 1, 2));
      run_vecs("run", 70);
      check("run vde cycles per frame", vde_cnt, 18);
      check("run frame_start count", fs_cnt, 3);
      check("run frame_done count", fd_cnt, 2);

      // Early stop finishes the frame, drains, start ignored in DRAIN
      vecs.delete();
      vecs.push_back(mk( 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(10, 0, 1, 0, 0, 1, 1, 1, 0, 0, 1, 1, 0));
      vecs.push_back(mk(11, 0, 0, 0, 0, 1, 2, 1, 0, 0, 1, 1, 0));
      vecs.push_back(mk(32, 0, 0, 0, 0, 3, 7, 0, 0, 0, 1, 1, 0));
      vecs.push_back(mk(33, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
      vecs.push_back(mk(34, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
      vecs.push_back(mk(35, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
      vecs.push_back(mk(36, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
      vecs.push_back(mk(37, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      run_vecs("stop", 45);
      check("stop frame_start count", fs_cnt, 1);
      check("stop frame_done count", fd_cnt, 1);

      // Mode offered with start in IDLE, then another in a frame_start+1 cycle
      vecs.delete();
      vecs.push_back(mk( 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(mk( 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0));
      vecs.push_back(mk(32, 0, 0, 0, 0, 3, 7, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(33, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1));
      vecs.push_back(mk(34, 0, 0, 1, 3, 0, 1, 1, 0, 0, 1, 1, 1));
      vecs.push_back(mk(35, 0, 0, 0, 0, 0, 2, 1, 0, 0, 1, 0, 1));
      vecs.push_back(mk(36, 0, 0, 0, 0, 0, 3, 1, 0, 1, 1, 0, 1));
      vecs.push_back(mk(64, 0, 0, 0, 0, 3, 7, 0, 0, 0, 1, 0, 1));
      vecs.push_back(mk(65, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 3));
      vecs.push_back(mk(66, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 3));
      run_vecs("mode", 70);
      check("mode frame_start count", fs_cnt, 3);

      // Stop coincident with the last pixel
      vecs.delete();
      vecs.push_back(mk( 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(32, 0, 1, 0, 0, 3, 7, 0, 0, 0, 1, 1, 0));
      vecs.push_back(mk(33, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
      vecs.push_back(mk(36, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
      vecs.push_back(mk(37, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      run_vecs("lastpix", 45);
      check("lastpix frame_start count", fs_cnt, 1);
      check("lastpix frame_done count", fd_cnt, 1);

      // IDLE mode apply, then asynchronous reset mid-frame
      apply_reset();
      step();                                   // cycle 0
      cfg_valid = 1'b1; cfg_mode = 2'd3;
      step();                                   // cycle 1
      check("idle c1 cfg_ready", int'(cfg_ready), 0);
      check("idle c1 active_mode", int'(active_mode), 0);
      step();                                   // cycle 2
      check("idle c2 active_mode", int'(active_mode), 3);
      check("idle c2 cfg_ready", int'(cfg_ready), 1);
      start = 1'b1;
      step();                                   // cycle 3
      check("idle c3 frame_start", int'(frame_start), 1);
      check("idle c3 active_mode", int'(active_mode), 3);
      step(); step();                           // cycle 5
      cfg_valid = 1'b1; cfg_mode = 2'd1;
      step();                                   // cycle 6
      check("idle c6 cfg_ready", int'(cfg_ready), 0);
      repeat (14) step();                       // cycle 20
      check("pre-reset busy", int'(busy), 1);
      check("pre-reset hcnt", int'(out_hcnt), 1);
      #2;
      rst = 1'b0;
      #1;
      check("rst vcnt", int'(out_vcnt), 0);
      check("rst hcnt", int'(out_hcnt), 0);
      check("rst vde", int'(out_vde), 0);
      check("rst frame_start", int'(frame_start), 0);
      check("rst frame_done", int'(frame_done), 0);
      check("rst busy", int'(busy), 0);
      check("rst cfg_ready", int'(cfg_ready), 1);
      check("rst active_mode", int'(active_mode), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      fd_cnt = 0; fs_cnt = 0; busy_cnt = 0;
      step();
      check("post-rst c0 busy", int'(busy), 0);
      check("post-rst c0 active_mode", int'(active_mode), 0);
      check("post-rst c0 cfg_ready", int'(cfg_ready), 1);
      for (int i = 0; i < 60; i++) begin
         if (frame_done)  fd_cnt++;
         if (frame_start) fs_cnt++;
         if (busy)        busy_cnt++;
         step();
      end
      check("post-rst frame_done count", fd_cnt, 0);
      check("post-rst frame_start count", fs_cnt, 0);
      check("post-rst busy cycles", busy_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
